// File: rtl/pipe_wreg_if.sv
// Memory-to-writeback bundle: m_* stage inputs, W_* control and registered outputs.
// The slave modport is the W register; master is whoever drives the memory stage.
interface pipe_wreg_if #(
    parameter int WORD_W  = 64,
    parameter int REG_W   = 4,
    parameter int ICODE_W = 4,
    parameter int STAT_W  = 4,
    parameter int CNT_W   = 32
);
    logic               W_stall;
    logic               W_bubble;
    logic [STAT_W-1:0]  m_stat;
    logic [ICODE_W-1:0] m_icode;
    logic [WORD_W-1:0]  m_valE;
    logic [WORD_W-1:0]  m_valM;
    logic [REG_W-1:0]   m_dstE;
    logic [REG_W-1:0]   m_dstM;

    logic [STAT_W-1:0]  W_stat;
    logic [ICODE_W-1:0] W_icode;
    logic [WORD_W-1:0]  W_valE;
    logic [WORD_W-1:0]  W_valM;
    logic [REG_W-1:0]   W_dstE;
    logic [REG_W-1:0]   W_dstM;
    logic               W_halted;
    logic [CNT_W-1:0]   instr_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
    logic [CNT_W-1:0]   stall_cnt;

    modport slave (
        input  W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
        output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, W_halted,
               instr_cnt, bubble_cnt, stall_cnt
    );

    modport master (
        output W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
        input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, W_halted,
               instr_cnt, bubble_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_wreg.sv
// Y86-64 memory-to-writeback pipeline register with stall/bubble control,
// sticky exception-halt freeze and saturating performance counters.
module pipe_wreg #(
    parameter int WORD_W    = 64,
    parameter int REG_W     = 4,
    parameter int ICODE_W   = 4,
    parameter int STAT_W    = 4,
    parameter int CNT_W     = 32,
    parameter int STAT_AOK  = 1,
    parameter int STAT_BUB  = 0,
    parameter int ICODE_NOP = 1,
    parameter int REG_NONE  = 15
) (
    input  logic       clk,
    input  logic       rst,
    pipe_wreg_if.slave bus
);

    localparam logic [STAT_W-1:0]  LP_AOK  = STAT_W'(STAT_AOK);
    localparam logic [STAT_W-1:0]  LP_BUB  = STAT_W'(STAT_BUB);
    localparam logic [ICODE_W-1:0] LP_NOP  = ICODE_W'(ICODE_NOP);
    localparam logic [REG_W-1:0]   LP_NONE = REG_W'(REG_NONE);

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [WORD_W-1:0]  valE;
        logic [WORD_W-1:0]  valM;
        logic [REG_W-1:0]   dstE;
        logic [REG_W-1:0]   dstM;
    } wreg_t;

    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_BUBBLE,
        UPD_STALL,
        UPD_FREEZE
    } upd_t;

    localparam wreg_t LP_BUBBLE_VAL = '{
        stat:  LP_BUB,
        icode: LP_NOP,
        valE:  '0,
        valM:  '0,
        dstE:  LP_NONE,
        dstM:  LP_NONE
    };

    wreg_t            r_w;
    logic             r_halted;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    wreg_t            w_m;
    upd_t             w_upd;
    logic             w_m_is_bub;
    logic             w_set_halt;
    logic             w_inc_instr;
    logic             w_inc_bubble;
    logic             w_inc_stall;

    always_comb begin
        w_m.stat  = bus.m_stat;
        w_m.icode = bus.m_icode;
        w_m.valE  = bus.m_valE;
        w_m.valM  = bus.m_valM;
        w_m.dstE  = bus.m_dstE;
        w_m.dstM  = bus.m_dstM;
    end

    // Priority below reset: freeze > stall > bubble > load.
    always_comb begin
        w_upd = UPD_LOAD;
        if (r_halted) begin
            w_upd = UPD_FREEZE;
        end else if (bus.W_stall) begin
            w_upd = UPD_STALL;
        end else if (bus.W_bubble) begin
            w_upd = UPD_BUBBLE;
        end
    end

    always_comb begin
        w_m_is_bub   = (bus.m_stat == LP_BUB);
        w_set_halt   = (w_upd == UPD_LOAD) && !w_m_is_bub && (bus.m_stat != LP_AOK);
        w_inc_instr  = (w_upd == UPD_LOAD) && !w_m_is_bub;
        w_inc_bubble = (w_upd == UPD_BUBBLE) || ((w_upd == UPD_LOAD) && w_m_is_bub);
        w_inc_stall  = (w_upd == UPD_STALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w          <= LP_BUBBLE_VAL;
            r_halted     <= 1'b0;
            r_instr_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            unique case (w_upd)
                UPD_LOAD:   r_w <= w_m;
                UPD_BUBBLE: r_w <= LP_BUBBLE_VAL;
                default:    r_w <= r_w;
            endcase

            if (w_set_halt) begin
                r_halted <= 1'b1;
            end

            // Counters saturate at all-ones rather than wrapping.
            if (w_inc_instr && (r_instr_cnt != '1)) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_inc_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_inc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.W_stat     = r_w.stat;
    assign bus.W_icode    = r_w.icode;
    assign bus.W_valE     = r_w.valE;
    assign bus.W_valM     = r_w.valM;
    assign bus.W_dstE     = r_w.dstE;
    assign bus.W_dstM     = r_w.dstM;
    assign bus.W_halted   = r_halted;
    assign bus.instr_cnt  = r_instr_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: doc/pipe_wreg.md
# pipe_wreg

Parametrised memory-to-writeback pipeline register for the pipelined Y86-64 core. It captures the memory-stage outputs (stat, icode, valE, valM, dstE, dstM) on each rising clock edge and presents them to the writeback stage and register file. It adds stall and bubble control, a sticky exception-halt freeze and saturating performance counters. It replaces the fixed-width, always-load W register.

## Interface
Parameters:
- WORD_W, 64, width of valE/valM
- REG_W, 4, width of dstE/dstM register IDs
- ICODE_W, 4, width of icode
- STAT_W, 4, width of stat
- CNT_W, 32, width of each performance counter
- STAT_AOK, 1, normal-status encoding
- STAT_BUB, 0, bubble-status encoding
- ICODE_NOP, 1, icode inserted for a bubble
- REG_NONE, 15, "no register" ID inserted for a bubble

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- W_stall  in  1  hold the current W contents
- W_bubble  in  1  load a bubble instead of the m_* inputs
- m_stat  in  STAT_W  memory-stage status
- m_icode  in  ICODE_W  memory-stage icode
- m_valE  in  WORD_W  ALU result
- m_valM  in  WORD_W  memory read value
- m_dstE  in  REG_W  destination register for valE
- m_dstM  in  REG_W  destination register for valM
- W_stat  out  STAT_W  registered status
- W_icode  out  ICODE_W  registered icode
- W_valE, W_valM  out  WORD_W  registered values
- W_dstE, W_dstM  out  REG_W  registered destinations
- W_halted  out  1  sticky: an exceptional stat has reached W
- instr_cnt  out  CNT_W  non-bubble instructions loaded into W
- bubble_cnt  out  CNT_W  cycles in which W receives a bubble
- stall_cnt  out  CNT_W  cycles held by W_stall

## Operation
- Update priority on each rising edge: rst > W_halted freeze > W_stall > W_bubble > normal load.
- **rst:** sets W_stat=STAT_BUB, W_icode=ICODE_NOP, W_valE=W_valM=0, W_dstE=W_dstM=REG_NONE, W_halted=0 and all counters to 0. These are also the reset values of every output.
- **Freeze:** while W_halted=1, all W_* outputs and all counters hold. W_stall and W_bubble are ignored. Only rst clears the freeze.
- **W_stall=1:** all W_* outputs hold. stall_cnt increments. W_bubble is ignored when asserted in the same cycle.
- **W_bubble=1** (without stall): loads the reset values of the W_* fields. bubble_cnt increments.
- **Normal load:** W_* takes m_*.
  - If m_stat==STAT_BUB, bubble_cnt increments.
  - Otherwise, instr_cnt increments.
- **Halt detect:** a normal load with m_stat not equal to STAT_AOK and not equal to STAT_BUB (HLT/ADR/INS) sets W_halted=1 on the same edge that loads W_stat.
- **Counters:** each counter saturates at all-ones and never wraps. At most one counter increments per cycle.

## Timing
- Latency is 1 cycle: m_* sampled at edge N appears on W_* after edge N.
- Outputs are purely registered. There is no combinational path from any input to any output.
- W_halted and the exceptional W_stat become visible in the same cycle.
- Reset asserted mid-stall or mid-freeze takes effect at the next edge. The first edge after rst deasserts performs a normal load.

## Test plan
- **Reset:** hold rst 2 cycles with m_valE=0xDEAD.
  - Required: W_stat=0, W_icode=1, W_dstE=W_dstM=15, W_valE=0, all counters=0.
- **Load:** stat=1, icode=6, valE=0x10, dstE=3, then stat=1, icode=5, valM=0x20, dstM=4.
  - Required: each set appears one cycle later; instr_cnt=2.
- **Stall vs bubble:** with W_stall=W_bubble=1 for 3 cycles on loaded data:
  - W holds its data; stall_cnt=3, bubble_cnt=0.
  - Next, W_bubble alone for 1 cycle gives W_stat=0, W_icode=1, W_dstE=15; bubble_cnt=1.
- **Halt freeze:** load stat=2 (HLT).
  - Required: W_halted=1 with W_stat=2.
  - Then 5 cycles of varying m_* and W_bubble leave W_* and all counters unchanged.
  - Applying rst clears W_halted.
- **Non-halting statuses:** loading m_stat=0 (bubble) gives bubble_cnt +1 with W_halted=0. Loading m_stat=1 (AOK) does not set W_halted.
- **Saturation:** with CNT_W=3, load 9 non-bubble AOK instructions.
  - Required: instr_cnt sticks at 7.
